// File: rtl/rs_dsp_mac_sequencer_if.sv
// rs_dsp_mac_sequencer_if
// Upstream bus of the RS_DSP MAC sequencer.
// It bundles the three valid/ready channels that connect the sequencer
// to the DMA / operand fetch engine.
//
// Signals:
//   cmd_*  : dot-product command (length N, shift, round, saturate, signedness)
//   op_*   : operand pair stream (A, B, plus op_sub when subtract is enabled)
//   res_*  : accumulated result returned to the fetch engine
//
// Modports:
//   master : the fetch engine side (it drives the commands and the operands)
//   slave  : the sequencer side
//
// Optional feature macro: RS_DSP_SEQ_SUBTRACT_EN adds the op_sub signal.
interface rs_dsp_mac_sequencer_if #(
    parameter int LEN_W = 8,
    parameter int A_W   = 20,
    parameter int B_W   = 18,
    parameter int Z_W   = 38
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [5:0]       cmd_shift;
    logic             cmd_round;
    logic             cmd_sat;
    logic             cmd_unsigned_a;
    logic             cmd_unsigned_b;

    logic             op_valid;
    logic             op_ready;
    logic [A_W-1:0]   op_a;
    logic [B_W-1:0]   op_b;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
    logic             op_sub;
`endif

    logic             res_valid;
    logic             res_ready;
    logic [Z_W-1:0]   res_data;

    modport master (
`ifdef RS_DSP_SEQ_SUBTRACT_EN
        output op_sub,
`endif
        output cmd_valid, cmd_len, cmd_shift, cmd_round, cmd_sat,
               cmd_unsigned_a, cmd_unsigned_b,
        input  cmd_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
`ifdef RS_DSP_SEQ_SUBTRACT_EN
        input  op_sub,
`endif
        input  cmd_valid, cmd_len, cmd_shift, cmd_round, cmd_sat,
               cmd_unsigned_a, cmd_unsigned_b,
        output cmd_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output res_valid, res_data,
        input  res_ready
    );
endinterface

// File: rtl/rs_dsp_mac_sequencer.sv
// rs_dsp_mac_sequencer
// Job-level sequencer for one RS_DSP tile in accumulate (MAC) mode.
// It accepts a dot-product command of length N and streams N operand pairs
// into the DSP. It keeps the DSP configuration pins constant for the whole
// job and pulses load_acc on the first pair. It then waits out the DSP
// pipeline and returns z_o through the result channel.
// Only one job is active at a time, so jobs never overlap.
//
// Ports:
//   clock, reset         : rising-edge clock and synchronous active-high reset
//   host (slave modport) : command, operand and result valid/ready channels
//   busy                 : high whenever a job is in progress (state != IDLE)
//   dsp_a_i, dsp_b_i     : registered operands sent to the DSP
//   dsp_load_acc         : high only on the first pair of a job
//   dsp_feedback         : constant 3'b000, which selects accumulate
//   dsp_unsigned_a/b, dsp_shift_right, dsp_round, dsp_saturate_enable :
//                          job configuration, captured when a command is accepted
//   dsp_subtract         : per-pair subtract (only with the optional feature)
//   dsp_z_o              : accumulator output coming back from the DSP
//
// Optional feature macro: RS_DSP_SEQ_SUBTRACT_EN adds op_sub to the operand
// channel and forwards it to dsp_subtract. When the macro is not defined,
// dsp_subtract is tied to 0.
module rs_dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 2,
    parameter int A_W     = 20,
    parameter int B_W     = 18,
    parameter int Z_W     = 38
) (
    input  logic                  clock,
    input  logic                  reset,
    rs_dsp_mac_sequencer_if.slave host,
    output logic                  busy,
    output logic [A_W-1:0]        dsp_a_i,
    output logic [B_W-1:0]        dsp_b_i,
    output logic                  dsp_load_acc,
    output logic [2:0]            dsp_feedback,
    output logic                  dsp_unsigned_a,
    output logic                  dsp_unsigned_b,
    output logic [5:0]            dsp_shift_right,
    output logic                  dsp_round,
    output logic                  dsp_saturate_enable,
    output logic                  dsp_subtract,
    input  logic [Z_W-1:0]        dsp_z_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;
    logic [2:0]       drain_q, drain_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             load_q, load_d;
    logic [5:0]       shift_q, shift_d;
    logic             round_q, round_d;
    logic             sat_q, sat_d;
    logic             ua_q, ua_d;
    logic             ub_q, ub_d;
    logic [Z_W-1:0]   res_q, res_d;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
    logic             sub_q, sub_d;
`endif

    // State register. It holds the FSM state, the job counters, the operand
    // registers that feed the DSP, the held configuration and the captured
    // result. A synchronous reset drops any job that is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            load_q      <= 1'b0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            ua_q        <= 1'b0;
            ub_q        <= 1'b0;
            res_q       <= '0;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            drain_q     <= drain_d;
            a_q         <= a_d;
            b_q         <= b_d;
            load_q      <= load_d;
            shift_q     <= shift_d;
            round_q     <= round_d;
            sat_q       <= sat_d;
            ua_q        <= ua_d;
            ub_q        <= ub_d;
            res_q       <= res_d;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
            sub_q       <= sub_d;
`endif
        end
    end

    // Next-state logic. The operand registers default to zero every cycle.
    // Bubbles in STREAM and every DRAIN cycle therefore add zero to the
    // accumulator. Only an accepted pair writes non-zero operands.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        drain_d     = drain_q;
        a_d         = '0;
        b_d         = '0;
        load_d      = 1'b0;
        shift_d     = shift_q;
        round_d     = round_q;
        sat_d       = sat_q;
        ua_d        = ua_q;
        ub_d        = ub_q;
        res_d       = res_q;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
        sub_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    if (host.cmd_len != '0) begin
                        shift_d     = host.cmd_shift;
                        round_d     = host.cmd_round;
                        sat_d       = host.cmd_sat;
                        ua_d        = host.cmd_unsigned_a;
                        ub_d        = host.cmd_unsigned_b;
                        remaining_d = host.cmd_len;
                        first_d     = 1'b1;
                        state_d     = STREAM;
                    end else begin
                        // An empty job never touches the DSP.
                        // It returns zero straight away.
                        res_d   = '0;
                        state_d = RESULT;
                    end
                end
            end
            STREAM: begin
                if (host.op_valid) begin
                    a_d     = host.op_a;
                    b_d     = host.op_b;
                    load_d  = first_q;
                    first_d = 1'b0;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
                    sub_d   = host.op_sub;
`endif
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    // DRAIN starts from DSP_LAT. The capture therefore
                    // happens DSP_LAT+1 edges after the last pair is
                    // registered, which is when its effect is on z_o.
                    if (remaining_q <= 1) begin
                        drain_d = 3'(DSP_LAT);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    res_d   = dsp_z_o;
                    state_d = RESULT;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            RESULT: begin
                if (host.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Each handshake ready/valid signal is decoded directly
    // from the state. All DSP pins come straight from registers, so nothing
    // combinational reaches the DSP.
    always_comb begin
        host.cmd_ready      = (state_q == IDLE);
        host.op_ready       = (state_q == STREAM);
        host.res_valid      = (state_q == RESULT);
        host.res_data       = res_q;
        busy                = (state_q != IDLE);
        dsp_a_i             = a_q;
        dsp_b_i             = b_q;
        dsp_load_acc        = load_q;
        dsp_feedback        = 3'b000;
        dsp_unsigned_a      = ua_q;
        dsp_unsigned_b      = ub_q;
        dsp_shift_right     = shift_q;
        dsp_round           = round_q;
        dsp_saturate_enable = sat_q;
`ifdef RS_DSP_SEQ_SUBTRACT_EN
        dsp_subtract        = sub_q;
`else
        dsp_subtract        = 1'b0;
`endif
    end

endmodule
